// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Program sequencer in front of the instruction decoder. It fetches words from
// a synchronous program ROM. It presents each opcode/operand pair for exactly
// one execute cycle. A WAIT opcode stalls the sequencer until resume is seen.
// At the end of the program the sequencer either wraps to address 0 or
// finishes. This block is the only owner of the program counter.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        begin a run from address 0 (honoured only in IDLE)
//   loop         at program end: 1 wraps to address 0, 0 finishes
//   resume       releases a WAIT stall (honoured only in STALL)
//   prog_en      ROM read enable (high in FETCH)
//   prog_addr    ROM read address, always equal to pc
//   prog_rdata   ROM data, valid the cycle after prog_en
//   opcode       registered opcode to the decoder
//   operand      registered operand to the datapath
//   instr_valid  execute strobe (high in EXEC only)
//   busy         high in every state except IDLE
//   done         one-cycle pulse at program completion
//   pc           current program counter
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int OPCODE_WIDTH  = 3,
  parameter int OPERAND_WIDTH = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int PROG_LEN      = 64,
  // Encoding of WAIT in the decoder's opcode table.
  parameter logic [OPCODE_WIDTH-1:0] WAIT_OPCODE = OPCODE_WIDTH'(6)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  loop,
  input  logic                                  resume,
  output logic                                  prog_en,
  output logic [ADDR_WIDTH-1:0]                 prog_addr,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] prog_rdata,
  output logic [OPCODE_WIDTH-1:0]               opcode,
  output logic [OPERAND_WIDTH-1:0]              operand,
  output logic                                  instr_valid,
  output logic                                  busy,
  output logic                                  done,
  output logic [ADDR_WIDTH-1:0]                 pc
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] STALL  = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_LEN - 1);

  logic [2:0]            state;
  logic [2:0]            adv_state;
  logic [ADDR_WIDTH-1:0] adv_pc;

  // Where an instruction goes when it retires, from EXEC or from STALL.
  // The end-of-program test is an explicit compare against the last address,
  // so any PROG_LEN works, including lengths that are not a power of two.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    adv_state = FIN;
    adv_pc    = pc;
    if (pc != LAST_ADDR) begin
      adv_state = FETCH;
      adv_pc    = pc + ADDR_WIDTH'(1);
    end else if (loop) begin
      adv_state = FETCH;
      adv_pc    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      opcode  <= '0;
      operand <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH:  state <= DECODE;
        DECODE: begin
          opcode  <= prog_rdata[OPCODE_WIDTH+OPERAND_WIDTH-1 -: OPCODE_WIDTH];
          operand <= prog_rdata[OPERAND_WIDTH-1:0];
          state   <= EXEC;
        end
        EXEC: begin
          // The instruction has already had its single strobe in this cycle.
          // A WAIT holds the sequencer here, and opcode and operand stay
          // visible during the stall.
          if (opcode == WAIT_OPCODE) begin
            state <= STALL;
          end else begin
            state <= adv_state;
            pc    <= adv_pc;
          end
        end
        STALL: begin
          if (resume) begin
            state <= adv_state;
            pc    <= adv_pc;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs are decoded from registers, so no input reaches an output
  // combinationally.
  assign prog_en     = (state == FETCH);
  assign prog_addr   = pc;
  assign instr_valid = (state == EXEC);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);

endmodule
